// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the pipeline MEM stage (cpu) and an
// external loader/debug port (ext), sequencing each access over MEM_LATENCY cycles.
module dmem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2,
    parameter int CPU_BURST   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_done,
    output logic              ext_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state | meaning
    // IDLE  | port free; arbitrate between cpu_req and ext_req
    // BUSY  | memory access in flight for MEM_LATENCY cycles
    // RESP  | one-cycle done pulse to the owner, no arbitration

    localparam int LAT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int BURST_W = $clog2(CPU_BURST + 1);
    localparam logic [LAT_W-1:0]   LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CPU_BURST);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state, state_nxt;
    logic                owner_ext, owner_ext_nxt;
    logic                we_q, we_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [DATA_W-1:0]   wdata_q, wdata_nxt;
    logic [LAT_W-1:0]    lat_cnt, lat_nxt;
    logic [BURST_W-1:0]  burst_cnt, burst_nxt;
    logic [DATA_W-1:0]   cpu_rdata_nxt, ext_rdata_nxt;
    logic                grant_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner_ext <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_cnt   <= '0;
            burst_cnt <= '0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
        end else begin
            state     <= state_nxt;
            owner_ext <= owner_ext_nxt;
            we_q      <= we_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            lat_cnt   <= lat_nxt;
            burst_cnt <= burst_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            ext_rdata <= ext_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_ext_nxt = owner_ext;
        we_nxt        = we_q;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        lat_nxt       = lat_cnt;
        burst_nxt     = burst_cnt;
        cpu_rdata_nxt = cpu_rdata;
        ext_rdata_nxt = ext_rdata;
        grant_ext     = 1'b0;
        case (state)
            IDLE: begin
                if (!ext_req)
                    burst_nxt = '0;
                if (cpu_req || ext_req) begin
                    // ext only beats a pending cpu once the cpu has used its burst
                    grant_ext     = ext_req && (!cpu_req || (burst_cnt == BURST_MAX));
                    state_nxt     = BUSY;
                    lat_nxt       = LAT_LOAD;
                    owner_ext_nxt = grant_ext;
                    if (grant_ext) begin
                        we_nxt    = ext_we;
                        addr_nxt  = ext_addr;
                        wdata_nxt = ext_wdata;
                        burst_nxt = '0;
                    end else begin
                        we_nxt    = cpu_we;
                        addr_nxt  = cpu_addr;
                        wdata_nxt = cpu_wdata;
                        if (ext_req && (burst_cnt != BURST_MAX))
                            burst_nxt = burst_cnt + 1'b1;
                    end
                end
            end
            BUSY: begin
                if (lat_cnt == '0) begin
                    state_nxt = RESP;
                    if (!we_q) begin
                        if (owner_ext)
                            ext_rdata_nxt = mem_rdata;
                        else
                            cpu_rdata_nxt = mem_rdata;
                    end
                end else begin
                    lat_nxt = lat_cnt - 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_en    = (state == BUSY);
    assign mem_we    = (state == BUSY) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_done  = (state == RESP) && !owner_ext;
    assign ext_done  = (state == RESP) && owner_ext;
    assign ext_gnt   = ((state == BUSY) || (state == RESP)) && owner_ext;
    assign cpu_stall = cpu_req && !cpu_done;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: agents push expected read data at issue,
// a negedge monitor pops on each done pulse and checks port timing and arbitration.
module tb_dmem_port_arbiter;
    localparam int AW = 32, DW = 32, LAT = 2, BURST = 4;

    logic clk = 1'b0, reset;
    logic cpu_req, cpu_we, ext_req, ext_we;
    logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
    logic cpu_done, cpu_stall, ext_done, ext_gnt, mem_en, mem_we;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .CPU_BURST(BURST)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_done(ext_done), .ext_gnt(ext_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // memory device and the reference image of its contents
    logic [DW-1:0] dev_mem [0:255];
    logic [DW-1:0] ref_mem [0:255];
    assign mem_rdata = dev_mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_en && mem_we) dev_mem[mem_addr[7:0]] <= mem_wdata;

    int n_checks = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] cpu_q[$], ext_q[$];
    logic [DW-1:0] cpu_last, ext_last, mon_exp;
    int  gnt_log[$];
    int  run, streak, cpu_done_cyc, ext_done_cyc;
    logic prev_en, prev_c, prev_e, exp_ext;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            run = 0; streak = 0; prev_en = 0; prev_c = 0; prev_e = 0;
        end else begin
            check("cpu_stall", cpu_stall, cpu_req & ~cpu_done);
            check("done_exclusive", cpu_done & ext_done, 0);
            if (cpu_done) begin
                cpu_done_cyc = cyc;
                check("cpu_latency", run, LAT);
                if (cpu_q.size() == 0) check("cpu_done_unexpected", cpu_done, 0);
                else begin mon_exp = cpu_q.pop_front(); check("cpu_rdata", cpu_rdata, mon_exp); end
            end
            if (ext_done) begin
                ext_done_cyc = cyc;
                check("ext_latency", run, LAT);
                if (ext_q.size() == 0) check("ext_done_unexpected", ext_done, 0);
                else begin mon_exp = ext_q.pop_front(); check("ext_rdata", ext_rdata, mon_exp); end
            end
            if (mem_en) begin
                if (!prev_en) begin
                    // winner of the preceding idle cycle, from the priority/burst rules
                    exp_ext = prev_e && (!prev_c || streak == BURST);
                    check("grant_owner", ext_gnt, exp_ext);
                    gnt_log.push_back(int'(ext_gnt));
                    if (exp_ext) streak = 0;
                    else if (prev_e && streak < BURST) streak++;
                end
                run++;
                check("mem_addr", mem_addr, ext_gnt ? ext_addr : cpu_addr);
                check("mem_we", mem_we, ext_gnt ? ext_we : cpu_we);
                if (mem_we) check("mem_wdata", mem_wdata, ext_gnt ? ext_wdata : cpu_wdata);
            end else begin
                if (!cpu_done && !ext_done) begin
                    check("ext_gnt_idle", ext_gnt, 0);
                    if (!ext_req) streak = 0;
                end
                run = 0;
            end
            prev_en = mem_en; prev_c = cpu_req; prev_e = ext_req;
        end
    end

    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n = 0;
        if (we) ref_mem[addr[7:0]] = wd;
        else cpu_last = ref_mem[addr[7:0]];
        cpu_q.push_back(cpu_last);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        do begin @(negedge clk); n++; end while (!cpu_done && n < 200);
        if (!cpu_done) begin check("cpu_done_timeout", cpu_done, 1); void'(cpu_q.pop_back()); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic ext_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n = 0;
        if (we) ref_mem[addr[7:0]] = wd;
        else ext_last = ref_mem[addr[7:0]];
        ext_q.push_back(ext_last);
        ext_we = we; ext_addr = addr; ext_wdata = wd; ext_req = 1'b1;
        do begin @(negedge clk); n++; end while (!ext_done && n < 200);
        if (!ext_done) begin check("ext_done_timeout", ext_done, 1); void'(ext_q.pop_back()); end
        @(posedge clk); #1;
        ext_req = 1'b0;
    endtask

    int exp_pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [DW-1:0] rv;

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
        cpu_last = '0; ext_last = '0;
        for (int i = 0; i < 256; i++) begin
            rv = $urandom; dev_mem[i] = rv; ref_mem[i] = rv;
        end
        dev_mem[8'h10] = 32'h55; ref_mem[8'h10] = 32'h55;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ext_rdata", ext_rdata, 0);
        check("rst_dones", {cpu_done, ext_done, ext_gnt, mem_we}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // CPU read with cycle-accurate timing
        fork
            cpu_access(1'b0, 32'h10, '0);
            begin
                @(negedge clk); check("rd_c0_stall", cpu_stall, 1); check("rd_c0_en", mem_en, 0);
                @(negedge clk); check("rd_c1_en", mem_en, 1);
                @(negedge clk); check("rd_c2_en", mem_en, 1); check("rd_c2_stall", cpu_stall, 1);
                @(negedge clk); check("rd_c3_done", cpu_done, 1); check("rd_c3_rdata", cpu_rdata, 32'h55);
                check("rd_c3_stall", cpu_stall, 0); check("rd_c3_en", mem_en, 0);
            end
        join

        // ext write followed by a CPU read of the same word
        fork
            ext_access(1'b1, 32'h20, 32'hDEADBEEF);
            begin
                @(negedge clk); check("wr_c0_gnt", ext_gnt, 0);
                @(negedge clk); check("wr_c1_gnt", ext_gnt, 1); check("wr_c1_we", mem_we, 1);
                @(negedge clk); check("wr_c2_gnt", ext_gnt, 1); check("wr_c2_we", mem_we, 1);
                @(negedge clk); check("wr_c3_gnt", ext_gnt, 1); check("wr_c3_done", ext_done, 1);
                check("wr_c3_we", mem_we, 0);
            end
        join
        cpu_access(1'b0, 32'h20, '0);

        // simultaneous single requests
        fork
            cpu_access(1'b0, 32'h11, '0);
            ext_access(1'b0, 32'h91, '0);
        join
        check("sim_done_spacing", ext_done_cyc - cpu_done_cyc, 4);

        // both continuously requesting
        gnt_log.delete();
        fork
            for (int i = 0; i < 8; i++) cpu_access(1'($urandom), {24'h0, 1'b0, 7'($urandom)}, $urandom);
            for (int i = 0; i < 2; i++) ext_access(1'($urandom), {24'h0, 1'b1, 7'($urandom)}, $urandom);
        join
        check("burst_grant_count", gnt_log.size(), 10);
        for (int i = 0; i < 10 && i < gnt_log.size(); i++)
            check($sformatf("burst_order[%0d]", i), gnt_log[i], exp_pat[i]);

        // reset in the second BUSY cycle of a CPU read
        cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_busy", mem_en, 1);
        reset = 1'b1; cpu_req = 1'b0;
        #1;
        check("mid_rst_en", mem_en, 0);
        check("mid_rst_done", cpu_done, 0);
        check("mid_rst_rdata", cpu_rdata, 0);
        repeat (2) begin
            @(negedge clk); check("rst_hold_en", mem_en, 0); check("rst_hold_done", cpu_done, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cpu_q.delete(); ext_q.delete(); cpu_last = '0; ext_last = '0;
        @(negedge clk); check("post_rst_idle_en", mem_en, 0); check("post_rst_done", cpu_done, 0);
        @(posedge clk); #1;
        cpu_access(1'b0, 32'h10, '0);

        // idle window
        repeat (20) begin
            @(negedge clk);
            check("idle_en", mem_en, 0); check("idle_stall", cpu_stall, 0);
            check("idle_done", {cpu_done, ext_done}, 0);
        end
        @(posedge clk); #1;

        // randomized traffic, disjoint address halves per requester
        fork
            for (int i = 0; i < 60; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                cpu_access(1'($urandom), {24'h0, 1'b0, 7'($urandom)}, $urandom);
            end
            for (int i = 0; i < 60; i++) begin
                repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
                ext_access(1'($urandom), {24'h0, 1'b1, 7'($urandom)}, $urandom);
            end
        join
        repeat (4) @(posedge clk);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("ext_q_drained", ext_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single DataMemory port between two requesters: the pipeline MEM stage (cpu) and an external loader/debug port (ext).
- Sequences each access over a fixed multi-cycle memory latency.
- Drives the stall back to the pipeline while the CPU access is pending.
- Gives the CPU priority, with a bounded burst so the ext requester cannot starve.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 2, memory cycles per access; legal range is 1 or more.
- CPU_BURST, 4, maximum consecutive CPU grants while ext_req is pending; legal range is 1 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM-stage access request; held stable until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  access address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  registered read data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  pipeline freeze.
- ext_req  in  1  ext access request; held stable until ext_done.
- ext_we  in  1  1 = write, 0 = read.
- ext_addr  in  ADDR_W  access address.
- ext_wdata  in  DATA_W  write data.
- ext_rdata  out  DATA_W  registered read data.
- ext_done  out  1  one-cycle completion pulse.
- ext_gnt  out  1  ext owns the memory port.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid on the last BUSY cycle.

Behaviour:
- Reset values (asynchronous): state=IDLE, owner=cpu, latency counter=0, burst counter=0. All outputs are 0, including both rdata registers.
- Reset mid-access: the access is aborted, no done pulse is issued, and no memory enable occurs after reset is asserted.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If cpu_req or ext_req is high, arbitrate and go to BUSY.
  - At the same edge, latch owner, we, addr and wdata from the winner, and load the latency counter with MEM_LATENCY-1.
  - If neither request is high, stay in IDLE.
- BUSY:
  - mem_en=1, mem_we=latched we; mem_addr and mem_wdata come from the latched registers.
  - The latched values are held stable for all MEM_LATENCY cycles.
  - The counter decrements each cycle. At the edge where the counter is 0:
    - For a read, mem_rdata is captured into the owner's rdata register.
    - For a write, that rdata register is unchanged.
    - The FSM goes to RESP.
- RESP:
  - Exactly one cycle with the owner's done=1 and mem_en=0. The FSM then returns to IDLE.
  - No arbitration happens in RESP.
- Latency: a request first seen in IDLE at cycle t gives BUSY in cycles t+1 … t+MEM_LATENCY, done at cycle t+MEM_LATENCY+1, and the next possible grant at the edge ending cycle t+MEM_LATENCY+2.
- Arbitration, evaluated in IDLE:
  - Only cpu_req: cpu wins.
  - Only ext_req: ext wins.
  - Both: cpu wins unless burst counter = CPU_BURST, in which case ext wins.
- Burst counter:
  - Increments on each cpu grant made while ext_req=1, saturating at CPU_BURST.
  - Clears on an ext grant, and in any IDLE cycle with ext_req=0.
- cpu_stall = cpu_req & ~cpu_done (combinational). The pipeline holds its request while stalled and advances in the done cycle.
- ext_gnt=1 during BUSY and RESP when owner=ext.
- Request dropped during BUSY: ignored; the access completes and done still pulses.
- Requests are never queued beyond the two input ports. Done never pulses for the non-owner.

Test Plan:
- CPU read (MEM_LATENCY=2; memory[0x10]=0x55), cpu_req high at cycle 0: mem_en=1 in cycles 1–2, cpu_done=1 and cpu_rdata=0x55 in cycle 3, cpu_stall=1 in cycles 0–2 and 0 in cycle 3.
- Ext write 0xDEADBEEF to 0x20, then CPU read of 0x20: ext_gnt=1 in cycles 1–3, mem_we=1 in cycles 1–2, cpu_rdata=0xDEADBEEF at its done cycle, ext_rdata unchanged.
- Simultaneous single requests from cpu and ext: cpu is served first and ext is served in the next slot. The two done pulses are 4 cycles apart and never overlap.
- Both requesters continuously requesting (CPU_BURST=4): grant order is C,C,C,C,E,C,C,C,C,E and ext_done pulses every fifth access.
- Reset asserted in the second BUSY cycle of a CPU read: outputs go to 0 immediately, no cpu_done, and the FSM is in IDLE after release. The re-issued request completes normally.
- No requests for 20 cycles: mem_en=0, cpu_stall=0, and no done pulses.
